// File: rtl/harmonic_sequencer_pkg.sv
// Shared definitions for the additive-oscillator sample sequencer and its
// DAC-side companions: state encoding, default framing constants, limit clamp.
package harmonic_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_START,
      ST_STEP,
      ST_DRAIN,
      ST_DONE,
      ST_CLEAR,
      ST_READY
   } seq_state_e;

   localparam int DEF_SAMPLE_INTERVAL = 1500;
   localparam int DEF_ACC_W           = 32;

   // A zero request still produces the fundamental; anything above the cap is clamped.
   function automatic logic [7:0] eff_limit(input logic [7:0] req, input logic [7:0] max_h);
      if (req == 8'd0) return 8'd1;
      if (req > max_h) return max_h;
      return req;
   endfunction

endpackage

// File: rtl/sample_tick_timer.sv
// Free-running modulo counter; o_Tick is high for the single wrap cycle.
// Shared with the ADC/DAC framing logic.
module sample_tick_timer
   import harmonic_sequencer_pkg::*;
#(
   parameter int INTERVAL = DEF_SAMPLE_INTERVAL
) (
   input  logic i_Clock,
   input  logic i_Reset_n,
   output logic o_Tick
);

   localparam int              CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(INTERVAL - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign o_Tick = (cnt_q == LAST);
   assign cnt_d  = o_Tick ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end

endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic loop: hands each harmonic to a scaling adder, collects
// the adder totals and fires the DAC send on the sample tick.
//
// state | meaning
// INIT  | capture harmonic limit and routing mode for this sample
// START | wait for sample value and target adder, issue harmonic
// STEP  | advance harmonic, step scaler; adders get a cycle to drop ready
// DRAIN | idle cycle after the last issue
// DONE  | wait for all adders idle, latch totals
// CLEAR | clear adder accumulators
// READY | wait for sample tick, send to DAC
module harmonic_sequencer
   import harmonic_sequencer_pkg::*;
#(
   parameter int MAX_HARMONICS   = 64,
   parameter int CHANNELS        = 2,
   parameter int SAMPLE_INTERVAL = DEF_SAMPLE_INTERVAL,
   parameter int ACC_W           = DEF_ACC_W
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset_n,
   input  logic [7:0]                i_Harmonic_Limit,
   input  logic                      i_Mode,
   input  logic                      i_Sample_Ready,
   input  logic                      i_Freq_Too_High,
   input  logic [CHANNELS-1:0]       i_Adder_Ready,
   input  logic [CHANNELS*ACC_W-1:0] i_Adder_Total,
   output logic [7:0]                o_Harmonic,
   output logic                      o_Next_Sample,
   output logic [CHANNELS-1:0]       o_Adder_Start,
   output logic                      o_Adder_Clear,
   output logic                      o_Mult_Start,
   output logic                      o_Mult_Restart,
   output logic [CHANNELS*ACC_W-1:0] o_Sample_Out,
   output logic                      o_DAC_Send,
   output logic                      o_Overrun,
   output logic [7:0]                o_Overrun_Count
);

   localparam logic [7:0] MAX8 = 8'(MAX_HARMONICS);
   localparam logic [7:0] CH8  = 8'(CHANNELS);

   seq_state_e                state_q;
   logic [7:0]                limit_q;
   logic                      mode_q;
   logic [7:0]                harm_q;
   logic                      next_sample_q;
   logic [CHANNELS-1:0]       adder_start_q;
   logic                      adder_clear_q;
   logic                      mult_start_q;
   logic                      mult_restart_q;
   logic [CHANNELS*ACC_W-1:0] sample_out_q;
   logic                      dac_send_q;
   logic                      overrun_q;
   logic [7:0]                ovr_cnt_q;

   logic                tick;
   logic [7:0]          lim_eff;
   logic [7:0]          ch_full;
   logic [CHANNELS-1:0] ch_oh;
   logic                ch_ready;
   logic                last_h;

   sample_tick_timer #(
      .INTERVAL (SAMPLE_INTERVAL)
   ) u_tick (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .o_Tick    (tick)
   );

   always_comb begin
      lim_eff = eff_limit(i_Harmonic_Limit, MAX8);
      ch_full = mode_q ? 8'd0 : (harm_q % CH8);
      ch_oh   = '0;
      for (int i = 0; i < CHANNELS; i++) ch_oh[i] = (ch_full == 8'(i));
      ch_ready = |(ch_oh & i_Adder_Ready);
      last_h   = (harm_q == limit_q - 8'd1);
   end

   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q        <= ST_INIT;
         limit_q        <= '0;
         mode_q         <= 1'b0;
         harm_q         <= '0;
         next_sample_q  <= 1'b0;
         adder_start_q  <= '0;
         adder_clear_q  <= 1'b0;
         mult_start_q   <= 1'b0;
         mult_restart_q <= 1'b0;
         sample_out_q   <= '0;
         dac_send_q     <= 1'b0;
         overrun_q      <= 1'b0;
         ovr_cnt_q      <= '0;
      end else begin
         next_sample_q  <= 1'b0;
         adder_start_q  <= '0;
         adder_clear_q  <= 1'b0;
         mult_start_q   <= 1'b0;
         mult_restart_q <= 1'b0;
         dac_send_q     <= 1'b0;
         overrun_q      <= 1'b0;

         // A tick outside READY is lost; the send slips to the following tick.
         if (tick && state_q != ST_READY) begin
            overrun_q <= 1'b1;
            if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
         end

         unique case (state_q)
            ST_INIT: begin
               limit_q <= lim_eff;
               mode_q  <= i_Mode;
               state_q <= ST_START;
            end
            ST_START: begin
               if (i_Sample_Ready && ch_ready) begin
                  next_sample_q <= 1'b1;
                  adder_start_q <= ch_oh;
                  state_q       <= (last_h || i_Freq_Too_High) ? ST_DRAIN : ST_STEP;
               end
            end
            ST_STEP: begin
               harm_q       <= harm_q + 8'd1;
               mult_start_q <= 1'b1;
               state_q      <= ST_START;
            end
            ST_DRAIN: state_q <= ST_DONE;
            ST_DONE: begin
               if (&i_Adder_Ready) begin
                  sample_out_q <= i_Adder_Total;
                  state_q      <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               adder_clear_q <= 1'b1;
               state_q       <= ST_READY;
            end
            ST_READY: begin
               if (tick) begin
                  dac_send_q     <= 1'b1;
                  mult_restart_q <= 1'b1;
                  harm_q         <= '0;
                  state_q        <= ST_INIT;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign o_Harmonic      = harm_q;
   assign o_Next_Sample   = next_sample_q;
   assign o_Adder_Start   = adder_start_q;
   assign o_Adder_Clear   = adder_clear_q;
   assign o_Mult_Start    = mult_start_q;
   assign o_Mult_Restart  = mult_restart_q;
   assign o_Sample_Out    = sample_out_q;
   assign o_DAC_Send      = dac_send_q;
   assign o_Overrun       = overrun_q;
   assign o_Overrun_Count = ovr_cnt_q;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Bench for harmonic_sequencer: two instances (2-channel/1500-clock and
// 4-channel/20-clock) with behavioural adder stubs and a start/total scoreboard.
module tb_harmonic_sequencer;

   localparam int ACC_W = 32;
   localparam int MAXH  = 64;
   localparam int CA    = 2;
   localparam int SIA   = 1500;
   localparam int CB    = 4;
   localparam int SIB   = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A ----------------
   logic                   rst_a, mode_a, srdy_a, ft_a, ft_en_a;
   logic [7:0]             lim_a;
   logic [CA-1:0]          ardy_a;
   logic [CA*ACC_W-1:0]    atot_a;
   logic [7:0]             harm_a, ovrc_a;
   logic                   ns_a, clr_a, ms_a, mr_a, send_a, ovr_a;
   logic [CA-1:0]          start_a;
   logic [CA*ACC_W-1:0]    sout_a;

   harmonic_sequencer #(
      .MAX_HARMONICS (MAXH), .CHANNELS (CA), .SAMPLE_INTERVAL (SIA), .ACC_W (ACC_W)
   ) u_dut_a (
      .i_Clock (clk), .i_Reset_n (rst_a), .i_Harmonic_Limit (lim_a), .i_Mode (mode_a),
      .i_Sample_Ready (srdy_a), .i_Freq_Too_High (ft_a), .i_Adder_Ready (ardy_a),
      .i_Adder_Total (atot_a), .o_Harmonic (harm_a), .o_Next_Sample (ns_a),
      .o_Adder_Start (start_a), .o_Adder_Clear (clr_a), .o_Mult_Start (ms_a),
      .o_Mult_Restart (mr_a), .o_Sample_Out (sout_a), .o_DAC_Send (send_a),
      .o_Overrun (ovr_a), .o_Overrun_Count (ovrc_a)
   );

   assign ft_a = ft_en_a && (harm_a == 8'd2);

   // Adder stub A: accumulates harmonic+1, busy for one cycle after each start.
   logic [ACC_W-1:0] acc_a [CA];
   logic [CA-1:0]    busy_a;
   always @(posedge clk) begin
      if (!rst_a || clr_a) begin
         for (int i = 0; i < CA; i++) acc_a[i] <= '0;
         busy_a <= '0;
      end else begin
         for (int i = 0; i < CA; i++)
            if (start_a[i]) acc_a[i] <= acc_a[i] + ACC_W'(harm_a) + ACC_W'(1);
         busy_a <= start_a;
      end
   end
   assign ardy_a = ~busy_a;
   always_comb begin
      atot_a = '0;
      for (int i = 0; i < CA; i++) atot_a[i*ACC_W +: ACC_W] = acc_a[i] + ACC_W'(i * 1000);
   end

   // ---------------- instance B ----------------
   logic                   rst_b, mode_b, srdy_b, ft_b;
   logic [7:0]             lim_b;
   logic [CB-1:0]          ardy_b;
   logic [CB*ACC_W-1:0]    atot_b;
   logic [7:0]             harm_b, ovrc_b;
   logic                   ns_b, clr_b, ms_b, mr_b, send_b, ovr_b;
   logic [CB-1:0]          start_b;
   logic [CB*ACC_W-1:0]    sout_b;

   harmonic_sequencer #(
      .MAX_HARMONICS (MAXH), .CHANNELS (CB), .SAMPLE_INTERVAL (SIB), .ACC_W (ACC_W)
   ) u_dut_b (
      .i_Clock (clk), .i_Reset_n (rst_b), .i_Harmonic_Limit (lim_b), .i_Mode (mode_b),
      .i_Sample_Ready (srdy_b), .i_Freq_Too_High (ft_b), .i_Adder_Ready (ardy_b),
      .i_Adder_Total (atot_b), .o_Harmonic (harm_b), .o_Next_Sample (ns_b),
      .o_Adder_Start (start_b), .o_Adder_Clear (clr_b), .o_Mult_Start (ms_b),
      .o_Mult_Restart (mr_b), .o_Sample_Out (sout_b), .o_DAC_Send (send_b),
      .o_Overrun (ovr_b), .o_Overrun_Count (ovrc_b)
   );

   logic [ACC_W-1:0] acc_b [CB];
   always @(posedge clk) begin
      if (!rst_b || clr_b) begin
         for (int i = 0; i < CB; i++) acc_b[i] <= '0;
      end else begin
         for (int i = 0; i < CB; i++)
            if (start_b[i]) acc_b[i] <= acc_b[i] + ACC_W'(harm_b) + ACC_W'(1);
      end
   end
   assign ardy_b = '1;
   always_comb begin
      atot_b = '0;
      for (int i = 0; i < CB; i++) atot_b[i*ACC_W +: ACC_W] = acc_b[i] + ACC_W'(i * 1000);
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [7:0] st;
      logic [7:0] h;
   } st_rec_t;

   st_rec_t      qa[$];
   st_rec_t      qb[$];
   logic [127:0] tot_qa[$];
   logic [127:0] tot_qb[$];
   bit           mon_a = 1'b0;
   bit           mon_b = 1'b0;
   int           ovr_seen_b = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected starts and totals for one sample of n harmonics.
   task automatic push_sample(input bit is_b, input int n, input bit mono, input int chans);
      int           sum[8];
      logic [127:0] tot;
      st_rec_t      r;
      int           c;
      tot = '0;
      for (int i = 0; i < 8; i++) sum[i] = i * 1000;
      for (int h = 0; h < n; h++) begin
         c      = mono ? 0 : h % chans;
         sum[c] = sum[c] + h + 1;
         r.st   = 8'(1 << c);
         r.h    = 8'(h);
         if (is_b) qb.push_back(r);
         else      qa.push_back(r);
      end
      for (int i = 0; i < chans; i++) tot[i*32 +: 32] = 32'(sum[i]);
      if (is_b) tot_qb.push_back(tot);
      else      tot_qa.push_back(tot);
   endtask

   always @(negedge clk) begin
      st_rec_t r;
      if (mon_a && |start_a) begin
         if (qa.size() == 0) chk("start_a_extra", 128'({start_a, harm_a}), 128'(0));
         else begin
            r = qa.pop_front();
            chk("start_a", 128'({start_a, harm_a}), 128'({r.st[CA-1:0], r.h}));
         end
      end
      if (mon_b && |start_b) begin
         if (qb.size() == 0) chk("start_b_extra", 128'({start_b, harm_b}), 128'(0));
         else begin
            r = qb.pop_front();
            chk("start_b", 128'({start_b, harm_b}), 128'({r.st[CB-1:0], r.h}));
         end
      end
      if (ovr_b) ovr_seen_b <= ovr_seen_b + 1;
   end

   task automatic wait_send_a(input int budget, output bit ok);
      ok = 1'b0;
      repeat (budget) begin
         @(negedge clk);
         if (send_a) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_a_arrived", 128'(ok), 128'(1));
   endtask

   task automatic wait_send_b(input int budget, output bit ok);
      ok = 1'b0;
      repeat (budget) begin
         @(negedge clk);
         if (send_b) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_b_arrived", 128'(ok), 128'(1));
   endtask

   task automatic check_send_a();
      logic [127:0] e;
      e = (tot_qa.size() != 0) ? tot_qa.pop_front() : '1;
      chk("totals_a", 128'(sout_a), e);
      chk("starts_a_all_issued", 128'(qa.size()), 128'(0));
   endtask

   task automatic check_send_b();
      logic [127:0] e;
      e = (tot_qb.size() != 0) ? tot_qb.pop_front() : '1;
      chk("totals_b", 128'(sout_b), e);
      chk("starts_b_all_issued", 128'(qb.size()), 128'(0));
   endtask

   initial begin
      bit ok;
      int r0;
      int last;
      int ob;

      rst_a = 1'b0; rst_b = 1'b0;
      lim_a = 8'd4; mode_a = 1'b0; srdy_a = 1'b1; ft_en_a = 1'b0;
      lim_b = 8'd5; mode_b = 1'b1; srdy_b = 1'b1; ft_b = 1'b0;
      repeat (3) @(negedge clk);

      chk("reset_a_outputs",
          128'({harm_a, ns_a, start_a, clr_a, ms_a, mr_a, send_a, ovr_a, ovrc_a}), 128'(0));
      chk("reset_a_sample_out", 128'(sout_a), 128'(0));
      chk("reset_b_outputs",
          128'({harm_b, ns_b, start_b, clr_b, ms_b, mr_b, send_b, ovr_b, ovrc_b}), 128'(0));

      // L=4 spread, two consecutive samples
      push_sample(1'b0, 4, 1'b0, CA);
      mon_a = 1'b1;
      rst_a = 1'b1;
      r0    = cyc;
      wait_send_a(SIA + 100, ok);
      chk("send_a_first_time", 128'(cyc - r0), 128'(SIA));
      check_send_a();

      push_sample(1'b0, 4, 1'b0, CA);
      last = cyc;
      wait_send_a(SIA + 100, ok);
      chk("send_a_spacing_l4", 128'(cyc - last), 128'(SIA));
      check_send_a();

      // Nyquist stop at harmonic 2 with L=50
      ft_en_a = 1'b1; lim_a = 8'd50;
      push_sample(1'b0, 3, 1'b0, CA);
      last = cyc;
      wait_send_a(SIA + 100, ok);
      chk("send_a_spacing_ft", 128'(cyc - last), 128'(SIA));
      check_send_a();

      // Limit 0 -> one harmonic
      ft_en_a = 1'b0; lim_a = 8'd0;
      push_sample(1'b0, 1, 1'b0, CA);
      last = cyc;
      wait_send_a(SIA + 100, ok);
      chk("send_a_spacing_l0", 128'(cyc - last), 128'(SIA));
      check_send_a();

      // Limit 200 -> clamped to 64
      lim_a = 8'd200;
      push_sample(1'b0, MAXH, 1'b0, CA);
      last = cyc;
      wait_send_a(SIA + 100, ok);
      chk("send_a_spacing_l200", 128'(cyc - last), 128'(SIA));
      check_send_a();

      // Asynchronous abort while in START
      lim_a = 8'd50;
      mon_a = 1'b0;
      ok = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (ns_a) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort_a_ns_seen", 128'(ok), 128'(1));
      @(posedge clk);
      #2 rst_a = 1'b0;
      #1;
      chk("abort_a_outputs",
          128'({harm_a, ns_a, start_a, clr_a, ms_a, mr_a, send_a, ovr_a, ovrc_a}), 128'(0));
      chk("abort_a_sample_out", 128'(sout_a), 128'(0));
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      ok = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (ns_a || (|start_a) || clr_a || ms_a || mr_a || send_a || ovr_a) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort_a_pulse_seen", 128'(ok), 128'(1));
      chk("abort_a_first_pulse", 128'({ns_a, harm_a}), 128'({1'b1, 8'd0}));
      chk("overrun_a_none", 128'(ovrc_a), 128'(0));

      // Instance B: mono, L=5, four channels
      push_sample(1'b1, 5, 1'b1, CB);
      mon_b = 1'b1;
      rst_b = 1'b1;
      r0    = cyc;
      wait_send_b(SIB + 50, ok);
      chk("send_b_mono_time", 128'(cyc - r0), 128'(SIB));
      check_send_b();
      chk("overrun_b_mono_none", 128'(ovrc_b), 128'(0));

      // Instance B: L=64 spread in a 20-clock slot -> 6 missed ticks per sample
      rst_b = 1'b0;
      lim_b = 8'd64; mode_b = 1'b0;
      push_sample(1'b1, MAXH, 1'b0, CB);
      repeat (2) @(negedge clk);
      ob    = ovr_seen_b;
      rst_b = 1'b1;
      r0    = cyc;
      wait_send_b(400, ok);
      chk("send_b_ovr_time", 128'(cyc - r0), 128'(7 * SIB));
      chk("overrun_b_pulses", 128'(ovr_seen_b - ob), 128'(6));
      chk("overrun_b_count", 128'(ovrc_b), 128'(6));
      check_send_b();

      push_sample(1'b1, MAXH, 1'b0, CB);
      last = cyc;
      wait_send_b(400, ok);
      chk("send_b_ovr_spacing", 128'(cyc - last), 128'(7 * SIB));
      chk("overrun_b_count2", 128'(ovrc_b), 128'(12));
      check_send_b();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/harmonic_sequencer.md
# harmonic_sequencer

- Parametrised per-sample controller for the additive oscillator.
- Once per sample period it steps through the active harmonics:
  - handshakes each harmonic with the sample-position generator;
  - dispatches it to one of CHANNELS scaling adders;
  - latches the adder totals and fires the DAC send.
- Generalises the fixed two-adder, fixed-count loop with: a runtime harmonic limit, N channels, a mono/spread routing mode, and overrun detection when the harmonic loop misses its sample slot.

## Interface
Parameters:
- MAX_HARMONICS, 64, upper bound on harmonics per sample
- CHANNELS, 2, number of adders/output channels (1..8)
- SAMPLE_INTERVAL, 1500, clocks per sample (72 MHz / 48 kHz)
- ACC_W, 32, adder accumulator width

Ports:
- i_Clock  in  1  main clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_Harmonic_Limit  in  8  requested harmonic count; 0 treated as 1; clamped to MAX_HARMONICS
- i_Mode  in  1  0 = spread (harmonic mod CHANNELS), 1 = mono (all to channel 0)
- i_Sample_Ready  in  1  sample-position value valid
- i_Freq_Too_High  in  1  current harmonic is above Nyquist
- i_Adder_Ready  in  CHANNELS  per-adder idle
- i_Adder_Total  in  CHANNELS*ACC_W  per-adder accumulator
- o_Harmonic  out  8  harmonic index being requested
- o_Next_Sample  out  1  1-cycle pulse: value consumed
- o_Adder_Start  out  CHANNELS  1-cycle one-hot start
- o_Adder_Clear  out  1  1-cycle accumulator clear
- o_Mult_Start  out  1  1-cycle pulse: step harmonic scaler
- o_Mult_Restart  out  1  1-cycle pulse: reload scaler
- o_Sample_Out  out  CHANNELS*ACC_W  latched totals
- o_DAC_Send  out  1  1-cycle pulse
- o_Overrun  out  1  1-cycle pulse: sample tick missed
- o_Overrun_Count  out  8  saturating missed-tick count

## Operation
- Reset values: all outputs 0, state INIT, timer 0, harmonic 0.
- Free-running timer counts 0..SAMPLE_INTERVAL-1 and wraps. The wrap cycle is the tick.
- Effective limit L = max(1, min(i_Harmonic_Limit, MAX_HARMONICS)). It is sampled in INIT and held for the whole sample.
- Target channel ch = (i_Mode ? 0 : o_Harmonic mod CHANNELS).
- State machine:
  - INIT → START.
  - START: wait for i_Sample_Ready && i_Adder_Ready[ch]. In that cycle, pulse o_Next_Sample and o_Adder_Start[ch], then increment o_Harmonic.
    - Go to DRAIN if o_Harmonic == L-1 or i_Freq_Too_High.
    - Otherwise go to STEP.
  - STEP: pulse o_Mult_Start → START. This gives one cycle for adders to drop ready.
  - DRAIN: one idle cycle → DONE.
  - DONE: wait until all i_Adder_Ready are high. Then latch every i_Adder_Total into o_Sample_Out → CLEAR.
  - CLEAR: pulse o_Adder_Clear → READY.
  - READY: on tick, pulse o_DAC_Send and o_Mult_Restart, zero o_Harmonic → INIT.
- A harmonic flagged i_Freq_Too_High is still issued, then the loop stops. Higher harmonics are skipped.
- Overrun:
  - A tick that arrives while not in READY pulses o_Overrun and increments o_Overrun_Count (saturates at 255).
  - No send occurs. The loop continues, and the send waits for the next tick.
- i_Harmonic_Limit and i_Mode changes mid-sample take effect only at the next INIT.
- Asynchronous reset mid-loop aborts immediately. o_Sample_Out is cleared, and the state returns to INIT with no pulses.

## Timing
- Per-harmonic issue costs 2 cycles minimum (START + STEP) when the inputs are already ready.
- Minimum loop cost is 2L + 4 cycles plus the adder drain. The design rule is that this must be ≤ SAMPLE_INTERVAL.
- o_Sample_Out is updated one cycle after all adders report ready, and is stable from then until the next DONE.
- o_DAC_Send is asserted in the cycle after the tick. Send-to-send spacing is exactly SAMPLE_INTERVAL when there is no overrun.
- All pulses are exactly 1 cycle. No combinational path exists from inputs to outputs.

## Structure
- Shared package holds the state encoding (INIT, START, STEP, DRAIN, DONE, CLEAR, READY) and the default SAMPLE_INTERVAL / ACC_W constants, for reuse by the top level and the DAC output module.
- One sub-module, sample_tick_timer: a parametrised modulo counter producing the 1-cycle tick. It is reusable by the ADC/DAC framing logic.

## Test plan
- L=4, spread, CHANNELS=2, inputs always ready:
  - o_Adder_Start sequence 01,10,01,10;
  - o_Harmonic 0..3;
  - one o_DAC_Send exactly 1500 clocks after the previous send.
- i_Freq_Too_High asserted at harmonic 2 with L=50: exactly 3 starts issued, then DRAIN/DONE, and the send occurs on schedule.
- Mono mode with CHANNELS=4 and L=5: all 5 starts on bit 0; o_Sample_Out channels 1..3 latch their (unchanged) totals.
- SAMPLE_INTERVAL=20 with L=64: o_Overrun pulses, the count increments, and the send follows on the next tick with the correct latched totals.
- i_Harmonic_Limit=0 → exactly 1 harmonic. i_Harmonic_Limit=200 with MAX_HARMONICS=64 → exactly 64 harmonics.
- i_Reset_n dropped while in START: all outputs 0 asynchronously; after release, the first pulse is o_Next_Sample with o_Harmonic=0.
